// File: rtl/debounce_pkg.sv
// Shared types and defaults for input debouncers: FSM state encoding and counter sizing.
// Used by inp_debounce; no logic of its own.
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    CHK_HIGH = 2'd1,
    HIGH     = 2'd2,
    CHK_LOW  = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_GLITCH_W      = 8;

  // Qualification counter must hold values up to STABLE_CYCLES.
  function automatic int cnt_width(input int stable_cycles);
    int w;
    w = $clog2(stable_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level into the clk domain.
// Latency: STAGES cycles from sampling edge to q; no flow control (free-running).
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/inp_debounce.sv
// Synchronizes and debounces a raw level; emits registered level, edge pulses, glitch count.
// Latency: SYNC_STAGES+STABLE_CYCLES-1 cycles from first sampling edge; no backpressure.
module inp_debounce
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int GLITCH_W      = DEF_GLITCH_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inp,
  output logic                out,
  output logic                rise,
  output logic                fall,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic          s;
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          out_nxt, rise_nxt, fall_nxt, glitch_inc;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (inp),
    .q     (s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOW;
      cnt        <= '0;
      out        <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      out   <= out_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
      if (glitch_inc && (glitch_cnt != '1)) begin
        glitch_cnt <= glitch_cnt + GLITCH_W'(1);
      end
    end
  end

  // An abort always returns to the idle state; the opposite check needs a fresh sample.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    out_nxt    = out;
    rise_nxt   = 1'b0;
    fall_nxt   = 1'b0;
    glitch_inc = 1'b0;
    unique case (state)
      LOW: begin
        cnt_nxt = '0;
        out_nxt = 1'b0;
        if (s) begin
          if (STABLE_CYCLES == 1) begin
            state_nxt = HIGH;
            out_nxt   = 1'b1;
            rise_nxt  = 1'b1;
          end else begin
            state_nxt = CHK_HIGH;
            cnt_nxt   = CW'(1);
          end
        end
      end
      CHK_HIGH: begin
        if (!s) begin
          state_nxt  = LOW;
          cnt_nxt    = '0;
          glitch_inc = 1'b1;
        end else if (cnt == LAST) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
          out_nxt   = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HIGH: begin
        cnt_nxt = '0;
        out_nxt = 1'b1;
        if (!s) begin
          if (STABLE_CYCLES == 1) begin
            state_nxt = LOW;
            out_nxt   = 1'b0;
            fall_nxt  = 1'b1;
          end else begin
            state_nxt = CHK_LOW;
            cnt_nxt   = CW'(1);
          end
        end
      end
      CHK_LOW: begin
        if (s) begin
          state_nxt  = HIGH;
          cnt_nxt    = '0;
          glitch_inc = 1'b1;
        end else if (cnt == LAST) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
          out_nxt   = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
        out_nxt   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_inp_debounce.sv
// Scoreboarded bench for inp_debounce with default parameters: edge pulses checked by
// a monitor against expected (kind, edge index) entries queued by the stimulus.
module tb_inp_debounce;
  import debounce_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inp = 1'b1;
  logic       out, rise, fall;
  logic [7:0] glitch_cnt;

  typedef struct {
    bit is_rise;
    int edge_idx;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  exp_glitch = 0;

  inp_debounce dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inp        (inp),
    .out        (out),
    .rise       (rise),
    .fall       (fall),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the next posedge is E0, so the pulse lands on edge E0+5.
  task automatic expect_ev(input bit is_rise);
    ev_t e;
    e.is_rise  = is_rise;
    e.edge_idx = cyc + 1 + 5;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse must match the oldest expected event in kind and edge index.
  always @(negedge clk) begin
    if (rst_n && (rise || fall)) begin
      chk("rise_fall_exclusive", int'(rise && fall), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse_rise", int'(rise), -1);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("pulse_kind_is_rise", int'(rise), int'(e.is_rise));
        chk("pulse_edge", cyc, e.edge_idx);
        chk("out_after_pulse", int'(out), int'(e.is_rise));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got t=%0t, expected completion", $time);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    // Reset held with inp=1: everything stays cleared.
    for (int i = 0; i < 3; i++) begin
      chk("rst_out", int'(out), 0);
      chk("rst_rise", int'(rise), 0);
      chk("rst_fall", int'(fall), 0);
      chk("rst_glitch", int'(glitch_cnt), 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    expect_ev(1'b1);
    wait_cyc(10);
    chk("post_rst_out", int'(out), 1);
    chk("post_rst_glitch", int'(glitch_cnt), 0);

    inp = 1'b0;
    expect_ev(1'b0);
    wait_cyc(10);
    chk("back_low_out", int'(out), 0);

    // Clean step held only 2 cycles: rejected.
    inp = 1'b1;
    wait_cyc(2);
    inp = 1'b0;
    exp_glitch++;
    wait_cyc(10);
    chk("short_step_out", int'(out), 0);
    chk("short_step_glitch", int'(glitch_cnt), exp_glitch);

    // Long pulse of 6 cycles: rise at E0+5, fall 6 edges later.
    inp = 1'b1;
    expect_ev(1'b1);
    wait_cyc(6);
    inp = 1'b0;
    expect_ev(1'b0);
    wait_cyc(12);
    chk("long_pulse_out", int'(out), 0);
    chk("long_pulse_glitch", int'(glitch_cnt), exp_glitch);

    // Bounce 1,0,1,0 then hold 1.
    inp = 1'b1; wait_cyc(1);
    inp = 1'b0; wait_cyc(1);
    inp = 1'b1; wait_cyc(1);
    inp = 1'b0; wait_cyc(1);
    inp = 1'b1;
    expect_ev(1'b1);
    exp_glitch += 2;
    wait_cyc(12);
    chk("bounce_out", int'(out), 1);
    chk("bounce_glitch", int'(glitch_cnt), exp_glitch);
    inp = 1'b0;
    expect_ev(1'b0);
    wait_cyc(10);

    // Saturation: 300 three-sample glitches.
    for (int i = 0; i < 300; i++) begin
      inp = 1'b1; wait_cyc(3);
      inp = 1'b0; wait_cyc(2);
      if (i == 99) begin
        wait_cyc(4);
        chk("sat_mid_glitch", int'(glitch_cnt), exp_glitch + 100);
      end
    end
    wait_cyc(6);
    chk("sat_glitch", int'(glitch_cnt), 255);
    for (int i = 0; i < 5; i++) begin
      inp = 1'b1; wait_cyc(3);
      inp = 1'b0; wait_cyc(2);
    end
    wait_cyc(6);
    chk("sat_hold_glitch", int'(glitch_cnt), 255);
    chk("sat_out", int'(out), 0);

    // Reset during CHK_HIGH with cnt=2 (after edge E0+3).
    inp = 1'b1;
    wait_cyc(4);
    chk("midchk_state", int'(dut.state), int'(CHK_HIGH));
    chk("midchk_cnt", int'(dut.cnt), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_state", int'(dut.state), int'(LOW));
    chk("midrst_out", int'(out), 0);
    chk("midrst_glitch", int'(glitch_cnt), 0);
    wait_cyc(3);
    rst_n = 1'b1;
    expect_ev(1'b1);
    wait_cyc(10);
    chk("midrst_rel_out", int'(out), 1);
    chk("midrst_rel_glitch", int'(glitch_cnt), 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inp_debounce.md
# inp_debounce

Upstream conditioning stage for the single-bit buffer path. Takes a raw, asynchronous, possibly bouncing `inp` level, synchronizes it into the `clk` domain, and filters it so that only levels held for a programmable number of consecutive cycles propagate. Its `out` drives the buffer's `inp` directly. It also emits single-cycle edge pulses and a saturating count of rejected glitches for debug.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flop count; legal range is ≥2.
- `STABLE_CYCLES`, default 4: consecutive synchronized samples required to accept a new level; legal range is ≥1.
- `GLITCH_W`, default 8: width of the glitch counter.
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `inp`  in  1  raw asynchronous level.
- `out`  out  1  debounced level, registered.
- `rise`  out  1  one-cycle pulse, coincident with `out` going 0→1.
- `fall`  out  1  one-cycle pulse, coincident with `out` going 1→0.
- `glitch_cnt`  out  GLITCH_W  saturating count of aborted level checks.

## Operation
- Synchronizer: a chain of `SYNC_STAGES` flops. `s` is the last stage. All stages reset to 0.
- The FSM has four states:
  - LOW: `out`=0. If `s`=1, go to CHK_HIGH and set `cnt`<=1. If `STABLE_CYCLES`==1, go straight to HIGH instead.
  - CHK_HIGH: `out`=0.
    - If `s`=0, go to LOW, clear `cnt`, and increment `glitch_cnt`.
    - Else, if `cnt`==`STABLE_CYCLES`-1, go to HIGH and pulse `rise`.
    - Else, `cnt`++.
  - HIGH and CHK_LOW: mirror images of LOW and CHK_HIGH, with `s` inverted and `fall` in place of `rise`.
- `cnt` width is clog2(`STABLE_CYCLES`+1). It is cleared in LOW and HIGH.
- `out`, `rise` and `fall` are flops, not state decodes, so the outputs are glitch-free.
- `rise` and `fall` are never high together. Each is high for exactly one cycle per accepted transition.
- `glitch_cnt` increments only on a CHK_*→LOW/HIGH abort and saturates at all-ones (no wrap).
- Reset (any time, including mid-check) asynchronously forces:
  - the state to LOW;
  - `cnt`, `out`, `rise` and `fall` to 0;
  - `glitch_cnt` to 0;
  - all synchronizer stages to 0.
- After reset, if `inp` is 1, the block qualifies it normally and produces one `rise` pulse.

## Timing
- E0 is the first rising edge that samples a new `inp` value into stage 1.
- `s` reflects the new value after edge E0+`SYNC_STAGES`-1.
- The FSM first sees the new value at edge E0+`SYNC_STAGES`.
- `out` and `rise`/`fall` update at edge E0+`SYNC_STAGES`+`STABLE_CYCLES`-1. With defaults this is E0+5, a latency of 5 cycles after E0.
- A level held on `s` for fewer than `STABLE_CYCLES` samples is rejected. `out` does not change and `glitch_cnt` increments by 1.
- A level held for exactly `STABLE_CYCLES` samples is accepted.
- Minimum spacing between accepted transitions is `STABLE_CYCLES` cycles.
- Mid-check reversal: the abort takes 1 cycle. The opposite check can start only from the idle state on the next sample, so a reversal in CHK_* never produces an accepted transition in the same cycle.

## Structure
- Shared package `debounce_pkg` holds:
  - the state enum (LOW, CHK_HIGH, HIGH, CHK_LOW), 2 bits;
  - the parameter defaults;
  - a `clog2`-based count-width helper.
- Sub-module `sync_ff` (parameter `STAGES`, asynchronous active-low reset to 0) is the synchronizer chain. It is reused by other async inputs in the design.
- The FSM, counter and glitch counter live in `inp_debounce` itself.

## Test plan
All scenarios use a 10-unit clock and default parameters.
- Reset: hold `rst_n`=0 with `inp`=1. Required: `out`=0, `rise`=`fall`=0, `glitch_cnt`=0 throughout reset. After release, `out`=1 exactly 5 edges after the first sampling edge, with a single `rise` pulse.
- Clean step: `inp` 0→1, held 20 units → `out` stays 0, because only 2 samples are seen. `glitch_cnt`=1 and there is no `rise`.
- Long pulse: `inp`=1 for 60 units, then 0. Required:
  - `out` rises at E0+5 with a 1-cycle `rise`;
  - `out` falls 5 edges after the falling E0 with a 1-cycle `fall`.
  - Pulse width on `out` equals 6 cycles.
- Bounce: `inp` toggles 1,0,1,0 at 10-unit spacing, then holds 1. Required: `out` rises once, `glitch_cnt`=2, and no `fall`.
- Saturation: 300 three-sample glitches → `glitch_cnt`=255 and it stays there.
- Reset mid-check: assert `rst_n`=0 while in CHK_HIGH, `cnt`=2. Required: the state is LOW immediately (asynchronous) and `out`=0. After release with `inp`=1, a full 5-edge latency is needed before `rise`.
